// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// Package : bus_pkg
// Purpose : Shared definitions for the CPU / DMA memory bus arbiter.
//           - arb_state_t : arbiter state encoding (IDLE/REQ/GRANT/RELEASE)
//           - BUS_ADDR_W / BUS_DATA_W : default bus widths
//           - RW_READ : direction encoding of a read cycle
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_GRANT   = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  localparam int BUS_ADDR_W = 16;
  localparam int BUS_DATA_W = 8;

  localparam logic RW_READ = 1'b1;

endpackage : bus_pkg

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// Module  : mem_bus_arbiter
// Purpose : Shares the single memory bus between the 6502 core and one
//           DMA-style requester. The CPU is halted through RDY, the arbiter
//           waits until the core sits on a read cycle (RDY is ignored on
//           writes), then hands the bus to the requester for a burst.
// Ports   :
//   clk        in   system clock, rising edge
//   RST        in   synchronous active-high reset
//   cpu_addr   in   CPU address            cpu_wdata in  CPU write data
//   cpu_rw     in   CPU direction (1=read) cpu_rdy   out CPU RDY (0=halt)
//   dma_req    in   requester wants bus / has a transfer this cycle
//   dma_addr   in   requester address      dma_wdata in  requester write data
//   dma_rw     in   requester direction    dma_gnt   out requester owns bus
//   dma_ack    out  transfer accepted this cycle
//   mem_addr / mem_wdata / mem_rw  out  muxed bus to memory decode
//   arb_state  out  current state encoding
// Config  : define ARB_BURST_LIMIT_EN to cap each grant at MAX_BURST acks.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mem_bus_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_W    = BUS_ADDR_W,
  parameter int DATA_W    = BUS_DATA_W,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_rw,
  output logic              cpu_rdy,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_rw,
  output logic              dma_gnt,
  output logic              dma_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rw,
  output logic [1:0]        arb_state
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
`ifdef ARB_BURST_LIMIT_EN
  localparam logic [CNT_W-1:0] c_LAST_ACK = CNT_W'(MAX_BURST - 1);
`endif

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_burst_cnt;
  logic             w_gnt;
  logic             w_ack;

  // Ownership flags come straight from the state register, so RDY and GNT
  // are glitch-free and can never be high together.
  assign w_gnt   = (r_state == ST_GRANT);
  assign w_ack   = w_gnt & dma_req;
  assign cpu_rdy = (r_state == ST_IDLE) || (r_state == ST_RELEASE);
  assign dma_gnt = w_gnt;
  assign dma_ack = w_ack;
  assign arb_state = r_state;

  assign mem_addr  = w_gnt ? dma_addr  : cpu_addr;
  assign mem_wdata = w_gnt ? dma_wdata : cpu_wdata;
  assign mem_rw    = w_gnt ? dma_rw    : cpu_rw;

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (dma_req) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        // A write cycle would not honour RDY, so only a read lets us grant.
        if (!dma_req)                w_state_nxt = ST_IDLE;
        else if (cpu_rw == RW_READ)  w_state_nxt = ST_GRANT;
      end
      ST_GRANT: begin
        if (!dma_req) w_state_nxt = ST_RELEASE;
`ifdef ARB_BURST_LIMIT_EN
        else if (r_burst_cnt == c_LAST_ACK) w_state_nxt = ST_RELEASE;
`endif
      end
      ST_RELEASE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Acks counted per grant; saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_burst_cnt <= '0;
    end else if (r_state == ST_RELEASE) begin
      r_burst_cnt <= '0;
    end else if (w_ack && (r_burst_cnt != c_CNT_MAX)) begin
      r_burst_cnt <= r_burst_cnt + 1'b1;
    end
  end

endmodule : mem_bus_arbiter

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// Module  : tb_mem_bus_arbiter
// Purpose : Self-checking bench for mem_bus_arbiter. A spec-level model
//           tracks ownership and per-grant ack counts; every cycle the DUT
//           outputs are compared against it, and directed scenarios pin
//           the model with literal expectations.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_bus_arbiter;

  localparam int MAXB = 4;
`ifdef ARB_BURST_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        RST;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rw;
  logic        cpu_rdy;
  logic        dma_req;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_rw;
  logic        dma_gnt;
  logic        dma_ack;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rw;
  logic [1:0]  arb_state;

  int checks = 0;
  int errors = 0;
  int acks   = 0;
  int gnts   = 0;
  bit en     = 1'b0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_BURST(MAXB)) dut (
    .clk(clk), .RST(RST),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rw(cpu_rw), .cpu_rdy(cpu_rdy),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_rw(dma_rw),
    .dma_gnt(dma_gnt), .dma_ack(dma_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw),
    .arb_state(arb_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- spec model ----------------
  // owner phase: 0 idle, 1 waiting for CPU read, 2 DMA owns bus, 3 hand-back
  int m_phase = 0;
  int m_taken = 0;   // acks taken in the current grant

  always @(posedge clk) begin
    if (RST) begin
      m_phase <= 0;
      m_taken <= 0;
    end else begin
      case (m_phase)
        0: if (dma_req) m_phase <= 1;
        1: if (!dma_req) m_phase <= 0; else if (cpu_rw) m_phase <= 2;
        2: begin
          if (dma_req) m_taken <= m_taken + 1;
          if (!dma_req) m_phase <= 3;
          else if (LIMIT && (m_taken + 1 >= MAXB)) m_phase <= 3;
        end
        default: begin
          m_phase <= 0;
          m_taken <= 0;
        end
      endcase
    end
  end

  // Compare process: mid low phase, after stimulus has settled.
  always @(negedge clk) begin
    #2;
    if (en) begin
      logic dma_owns;
      dma_owns = (m_phase == 2);
      check("state",     32'(arb_state), 32'(m_phase));
      check("cpu_rdy",   32'(cpu_rdy),   32'(m_phase == 0 || m_phase == 3));
      check("dma_gnt",   32'(dma_gnt),   32'(dma_owns));
      check("dma_ack",   32'(dma_ack),   32'(dma_owns && dma_req));
      check("mem_addr",  32'(mem_addr),  32'(dma_owns ? dma_addr : cpu_addr));
      check("mem_wdata", 32'(mem_wdata), 32'(dma_owns ? dma_wdata : cpu_wdata));
      check("mem_rw",    32'(mem_rw),    32'(dma_owns ? dma_rw : cpu_rw));
      if (dma_ack) acks++;
      if (dma_gnt) gnts++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  int a0;
  int g0;

  initial begin
    RST = 1'b1; dma_req = 1'b1; cpu_addr = 16'hFFFC; cpu_wdata = 8'h11; cpu_rw = 1'b1;
    dma_addr = 16'h0200; dma_wdata = 8'hA5; dma_rw = 1'b0;

    // Reset held two cycles with a pending request
    tick(); tick();
    check("rst_rdy",   32'(cpu_rdy), 32'd1);
    check("rst_gnt",   32'(dma_gnt), 32'd0);
    check("rst_ack",   32'(dma_ack), 32'd0);
    check("rst_state", 32'(arb_state), 32'd0);
    check("rst_addr",  32'(mem_addr), 32'hFFFC);
    RST = 1'b0; dma_req = 1'b0; en = 1'b1;
    tick();

    // Basic grant: 3 acks then release
    cpu_addr = 16'h1234; dma_req = 1'b1;
    tick();
    check("bg_rdy0",  32'(cpu_rdy), 32'd0);
    check("bg_gnt0",  32'(dma_gnt), 32'd0);
    check("bg_req",   32'(arb_state), 32'd1);
    a0 = acks;
    tick();
    check("bg_gnt1",  32'(dma_gnt), 32'd1);
    check("bg_addr",  32'(mem_addr), 32'h0200);
    check("bg_wdata", 32'(mem_wdata), 32'hA5);
    check("bg_rw",    32'(mem_rw), 32'd0);
    tick(); tick();
    dma_req = 1'b0;
    tick();
    check("bg_acks", 32'(acks - a0), 32'd3);
    check("bg_rel",  32'(arb_state), 32'd3);
    check("bg_rdy1", 32'(cpu_rdy), 32'd1);
    tick();
    check("bg_idle", 32'(arb_state), 32'd0);
    check("bg_rdy2", 32'(cpu_rdy), 32'd1);

    // Write wait: CPU writing for 3 cycles in REQ
    cpu_rw = 1'b0; dma_req = 1'b1; dma_addr = 16'h0300; dma_rw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ww_gnt0",  32'(dma_gnt), 32'd0);
      check("ww_state", 32'(arb_state), 32'd1);
    end
    cpu_rw = 1'b1;
    tick();
    check("ww_gnt1", 32'(dma_gnt), 32'd1);
    dma_req = 1'b0;
    tick(); tick();

    // Abort: one-cycle request pulse
    g0 = gnts; a0 = acks;
    dma_req = 1'b1;
    tick();
    check("ab_req", 32'(arb_state), 32'd1);
    dma_req = 1'b0;
    tick();
    check("ab_idle", 32'(arb_state), 32'd0);
    tick();
    check("ab_nognt", 32'(gnts - g0), 32'd0);
    check("ab_noack", 32'(acks - a0), 32'd0);

    // Held request: limited vs. continuous bursts over 16 cycles
    a0 = acks;
    dma_req = 1'b1; dma_wdata = 8'h3C;
    repeat (16) tick();
    check("bl_acks",  32'(acks - a0), LIMIT ? 32'd9 : 32'd15);
    check("bl_state", 32'(arb_state), 32'd2);
    dma_req = 1'b0;
    tick(); tick();

    // Reset during the second ack
    dma_req = 1'b1;
    tick(); tick(); tick();
    check("rm_ack2", 32'(dma_ack), 32'd1);
    RST = 1'b1;
    tick();
    check("rm_gnt",   32'(dma_gnt), 32'd0);
    check("rm_rdy",   32'(cpu_rdy), 32'd1);
    check("rm_state", 32'(arb_state), 32'd0);
    RST = 1'b0;
    a0 = acks;
    repeat (6) tick();
    // a fresh grant must allow a full burst again (count was cleared)
    check("rm_acks",  32'(acks - a0), LIMIT ? 32'd4 : 32'd5);
    check("rm_after", 32'(arb_state), LIMIT ? 32'd3 : 32'd2);
    dma_req = 1'b0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mem_bus_arbiter

`default_nettype wire
